// File: rtl/lisa_lsu_ctrl_if.sv
// Core-request / memory-bus bundle for the LISA load-store unit.
// The master modport is the LSU controller itself; slave is the core+memory environment.
interface lisa_lsu_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lisa_lsu_ctrl.sv
// LISA load-store controller: one outstanding access, lane steering, load extension
// and an ack timeout; every access ends with a single-cycle response.
module lisa_lsu_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  lisa_lsu_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [15:0]       wait_cnt;
  logic              lat_we;
  logic              lat_signed;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              req_bad;
  logic              accept;
  logic              ack_done;
  logic              time_out;
  logic [31:0]       rd_shift;
  logic [31:0]       load_data;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;

  assign req_bad = (bus.req_size == 2'd3)
                || (bus.req_size == 2'd1 && bus.req_addr[0])
                || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_done   = 1'b0;
    time_out   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = req_bad ? RESP : MEM;
        end
      end
      MEM: begin
        // An ack on the final allowed cycle beats the timeout.
        if (bus.mem_ack) begin
          ack_done   = 1'b1;
          state_next = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          time_out   = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_data  = resp_data_q;
    bus.resp_err   = resp_err_q;
    bus.mem_req    = (state == MEM);
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = 4'b0000;
    bus.mem_wdata  = 32'd0;
    if (state == MEM) begin
      bus.mem_we   = lat_we;
      bus.mem_addr = {lat_addr[ADDR_W-1:2], 2'b00};
      case (lat_size)
        2'd0: begin
          bus.mem_be    = 4'b0001 << lat_addr[1:0];
          bus.mem_wdata = {4{lat_wdata[7:0]}};
        end
        2'd1: begin
          bus.mem_be    = 4'b0011 << lat_addr[1:0];
          bus.mem_wdata = {2{lat_wdata[15:0]}};
        end
        default: begin
          bus.mem_be    = 4'b1111;
          bus.mem_wdata = lat_wdata;
        end
      endcase
    end
  end

  always_comb begin
    rd_shift = bus.mem_rdata >> {lat_addr[1:0], 3'b000};
    case (lat_size)
      2'd0:    load_data = {{24{lat_signed & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_data = {{16{lat_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 16'd0;
      lat_we      <= 1'b0;
      lat_signed  <= 1'b0;
      lat_size    <= 2'd0;
      lat_addr    <= '0;
      lat_wdata   <= 32'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_we     <= bus.req_we;
        lat_signed <= bus.req_signed;
        lat_size   <= bus.req_size;
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
      end
      // Counter is zero on every entry to MEM because it idles at zero elsewhere.
      if (state == MEM && !bus.mem_ack)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= 16'd0;
      resp_data_q <= (ack_done && !lat_we) ? load_data : 32'd0;
      resp_err_q  <= (accept && req_bad) || time_out;
    end
  end
endmodule
